// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: register file plus ALU in a two-stage issue/writeback
// pipeline. Stage 1 reads operands (optionally bypassing the pending
// writeback), computes the ALU result and registers it onto LED/OF/ZF.
// Stage 2 commits the registered result into the register file one edge
// later. Register 0 is hardwired to zero and is never a bypass source.

module alu_regfile_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit FORWARD = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic              Write_Reg,
  input  logic              Use_Imm,
  input  logic [DATA_W-1:0] Imm,
  input  logic [2:0]        ALU_OP,
  output logic [DATA_W-1:0] LED,
  output logic              OF,
  output logic              ZF,
  output logic              out_valid,
  input  logic [ADDR_W-1:0] Dbg_Addr,
  output logic [DATA_W-1:0] Dbg_Data
);

  localparam int NREG = 1 << ADDR_W;
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  logic [DATA_W-1:0] rf [NREG];

  // pending stage-2 writeback
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [SH_W-1:0]   shamt;
  logic              slt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_of;

  // bypass hit detection; r0 is never a bypass target
  always_comb begin
    fwd_a = FORWARD && wb_en && (wb_addr == R_Addr_A) && (R_Addr_A != '0);
    fwd_b = FORWARD && wb_en && (wb_addr == R_Addr_B) && (R_Addr_B != '0);
  end

  // operand read from the file, then bypass and immediate selection
  always_comb begin
    rd_a = (R_Addr_A == '0) ? '0 : rf[R_Addr_A];
    rd_b = (R_Addr_B == '0) ? '0 : rf[R_Addr_B];
    op_a = fwd_a ? wb_data : rd_a;
    if (Use_Imm) begin
      op_b = Imm;
    end else begin
      op_b = fwd_b ? wb_data : rd_b;
    end
  end

  // ALU: result and signed overflow; SLT uses a true signed compare so it
  // stays correct when A-B overflows
  always_comb begin
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    shamt   = op_b[SH_W-1:0];
    slt     = $signed(op_a) < $signed(op_b);
    alu_res = '0;
    alu_of  = 1'b0;
    case (ALU_OP)
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOR: alu_res = ~(op_a | op_b);
      OP_ADD: begin
        alu_res = sum;
        alu_of  = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_of  = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, slt};
      OP_SLL: alu_res = op_a << shamt;
    endcase
  end

  // stage-1 capture: result/flag registers and the pending writeback
  always_ff @(posedge clk) begin
    if (Reset) begin
      LED       <= '0;
      OF        <= 1'b0;
      ZF        <= 1'b0;
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else if (in_valid) begin
      LED       <= alu_res;
      OF        <= alu_of;
      ZF        <= (alu_res == '0);
      out_valid <= 1'b1;
      wb_en     <= Write_Reg && (W_Addr != '0);
      wb_addr   <= W_Addr;
      wb_data   <= alu_res;
    end else begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
    end
  end

  // stage-2 architectural write; reset cancels a write pending from the
  // previous edge because it takes priority here
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // debug port shows committed contents only
  always_comb begin
    Dbg_Data = (Dbg_Addr == '0) ? '0 : rf[Dbg_Addr];
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Bench for alu_regfile_pipe: two instances (bypass on / off) share stimulus.
// A sequential-semantics model predicts LED/OF/ZF/out_valid/Dbg_Data each
// cycle; a directed prologue pins hand-computed values.

module tb_alu_regfile_pipe;

  logic        clk;
  logic        Reset;
  logic        in_valid;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [4:0]  W_Addr;
  logic        Write_Reg;
  logic        Use_Imm;
  logic [31:0] Imm;
  logic [2:0]  ALU_OP;
  logic [4:0]  Dbg_Addr;

  logic [31:0] led1, led0, dbg1, dbg0;
  logic        of1, of0, zf1, zf0, ov1, ov0;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] AND_ = 3'd0, OR_ = 3'd1, XOR_ = 3'd2, NOR_ = 3'd3;
  localparam logic [2:0] ADD_ = 3'd4, SUB_ = 3'd5, SLT_ = 3'd6, SLL_ = 3'd7;

  alu_regfile_pipe #(.DATA_W(32), .ADDR_W(5), .FORWARD(1'b1)) dut_fwd (
    .clk(clk), .Reset(Reset), .in_valid(in_valid),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
    .Write_Reg(Write_Reg), .Use_Imm(Use_Imm), .Imm(Imm), .ALU_OP(ALU_OP),
    .LED(led1), .OF(of1), .ZF(zf1), .out_valid(ov1),
    .Dbg_Addr(Dbg_Addr), .Dbg_Data(dbg1)
  );

  alu_regfile_pipe #(.DATA_W(32), .ADDR_W(5), .FORWARD(1'b0)) dut_nofwd (
    .clk(clk), .Reset(Reset), .in_valid(in_valid),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
    .Write_Reg(Write_Reg), .Use_Imm(Use_Imm), .Imm(Imm), .ALU_OP(ALU_OP),
    .LED(led0), .OF(of0), .ZF(zf0), .out_valid(ov0),
    .Dbg_Addr(Dbg_Addr), .Dbg_Data(dbg0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference ALU in plain wide arithmetic
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic of);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    of = 1'b0;
    r  = 32'd0;
    case (op)
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      NOR_: r = ~(a | b);
      ADD_: begin s = sa + sb; r = s[31:0]; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      SUB_: begin s = sa - sb; r = s[31:0]; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      SLT_: r = (sa < sb) ? 32'd1 : 32'd0;
      SLL_: r = a << b[4:0];
    endcase
  endfunction

  // model: index 1 = bypass instance (reads see every earlier issue),
  // index 0 = no bypass (reads see committed file only)
  logic [31:0] m_seq  [2][32];
  logic [31:0] m_file [2][32];
  logic [31:0] e_led [2];
  logic        e_of [2], e_zf [2], e_ov [2];
  logic        p_en [2];
  logic [4:0]  p_addr [2];
  logic [31:0] p_data [2];
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    logic [31:0] a, b, r;
    logic        of;
    for (int d = 0; d < 2; d++) begin
      if (Reset) begin
        for (int i = 0; i < 32; i++) begin
          m_seq[d][i]  = 32'd0;
          m_file[d][i] = 32'd0;
        end
        e_led[d] = 32'd0; e_of[d] = 1'b0; e_zf[d] = 1'b0; e_ov[d] = 1'b0;
        p_en[d] = 1'b0; p_addr[d] = 5'd0; p_data[d] = 32'd0;
      end else begin
        r = 32'd0; of = 1'b0;
        if (in_valid) begin
          a = (d == 1) ? m_seq[d][R_Addr_A] : m_file[d][R_Addr_A];
          b = Use_Imm ? Imm : ((d == 1) ? m_seq[d][R_Addr_B] : m_file[d][R_Addr_B]);
          ref_alu(ALU_OP, a, b, r, of);
        end
        if (p_en[d]) m_file[d][p_addr[d]] = p_data[d];
        if (in_valid) begin
          e_led[d] = r; e_of[d] = of; e_zf[d] = (r == 32'd0); e_ov[d] = 1'b1;
          p_en[d]   = Write_Reg && (W_Addr != 5'd0);
          p_addr[d] = W_Addr;
          p_data[d] = r;
          if (p_en[d]) m_seq[d][W_Addr] = r;
        end else begin
          e_ov[d] = 1'b0;
          p_en[d] = 1'b0;
        end
      end
    end
    if (Reset) model_live = 1'b1;
  end

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (model_live) begin
      chk("led_fwd",   led1,        e_led[1]);
      chk("of_fwd",    32'(of1),    32'(e_of[1]));
      chk("zf_fwd",    32'(zf1),    32'(e_zf[1]));
      chk("ov_fwd",    32'(ov1),    32'(e_ov[1]));
      chk("dbg_fwd",   dbg1,        m_file[1][Dbg_Addr]);
      chk("led_nofwd", led0,        e_led[0]);
      chk("of_nofwd",  32'(of0),    32'(e_of[0]));
      chk("zf_nofwd",  32'(zf0),    32'(e_zf[0]));
      chk("ov_nofwd",  32'(ov0),    32'(e_ov[0]));
      chk("dbg_nofwd", dbg0,        m_file[0][Dbg_Addr]);
    end
  end

  // drive one issue at the current negedge, return at the next negedge
  task automatic issue(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] wa, input logic wr, input logic ui,
                       input logic [31:0] imm);
    in_valid = 1'b1; ALU_OP = op; R_Addr_A = ra; R_Addr_B = rb; W_Addr = wa;
    Write_Reg = wr; Use_Imm = ui; Imm = imm;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; Write_Reg = 1'b0;
    @(negedge clk);
  endtask

  task automatic dbg_chk(input string name, input bit fwd_inst, input logic [4:0] addr,
                         input logic [31:0] exp);
    Dbg_Addr = addr;
    #1;
    chk(name, fwd_inst ? dbg1 : dbg0, exp);
  endtask

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    Reset = 1'b1; in_valid = 1'b0; R_Addr_A = 5'd0; R_Addr_B = 5'd0; W_Addr = 5'd0;
    Write_Reg = 1'b0; Use_Imm = 1'b0; Imm = 32'd0; ALU_OP = 3'd0; Dbg_Addr = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset_led", led1, 32'd0);
    chk("reset_ov",  32'(ov1), 32'd0);
    Reset = 1'b0;

    // back-to-back dependent adds
    issue(ADD_, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5);
    chk("add_imm5", led1, 32'd5);
    chk("add_imm5_ov", 32'(ov1), 32'd1);
    issue(ADD_, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 32'd3);
    chk("dep_add_fwd", led1, 32'd8);
    chk("dep_add_nofwd", led0, 32'd3);
    chk("dep_add_ov", 32'(ov1), 32'd1);
    idle();
    idle();
    dbg_chk("dbg_r1", 1'b1, 5'd1, 32'd5);
    dbg_chk("dbg_r2", 1'b1, 5'd2, 32'd8);
    dbg_chk("dbg_r2_nofwd", 1'b0, 5'd2, 32'd3);

    // signed overflow boundaries
    issue(ADD_, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'h7FFF_FFFF);
    issue(ADD_, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 32'd1);
    chk("add_ovf_led", led1, 32'h8000_0000);
    chk("add_ovf_of", 32'(of1), 32'd1);
    chk("add_ovf_zf", 32'(zf1), 32'd0);
    issue(SUB_, 5'd4, 5'd0, 5'd5, 1'b1, 1'b1, 32'd1);
    chk("sub_ovf_led", led1, 32'h7FFF_FFFF);
    chk("sub_ovf_of", 32'(of1), 32'd1);

    // zero flag, shift, signed compare
    issue(SUB_, 5'd1, 5'd1, 5'd6, 1'b1, 1'b0, 32'd0);
    chk("sub_self_led", led1, 32'd0);
    chk("sub_self_zf", 32'(zf1), 32'd1);
    chk("sub_self_of", 32'(of1), 32'd0);
    issue(SLL_, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 32'd4);
    chk("sll_led", led1, 32'd80);
    issue(ADD_, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(SLT_, 5'd10, 5'd1, 5'd11, 1'b1, 1'b0, 32'd0);
    chk("slt_neg_led", led1, 32'd1);

    // r0 writes discarded and never bypassed
    issue(ADD_, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'd9);
    chk("r0_write_led", led1, 32'd9);
    issue(ADD_, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'd0);
    chk("r0_read_led", led1, 32'd0);
    chk("r0_read_zf", 32'(zf1), 32'd1);
    idle();
    dbg_chk("dbg_r0", 1'b1, 5'd0, 32'd0);

    // reset on the edge the write would land
    issue(ADD_, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'd7);
    Reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    dbg_chk("rst_cancel_r9", 1'b1, 5'd9, 32'd0);
    chk("rst_led", led1, 32'd0);
    chk("rst_ov", 32'(ov1), 32'd0);
    chk("rst_of", 32'(of1), 32'd0);
    chk("rst_zf", 32'(zf1), 32'd0);

    // Write_Reg=0 then a gap: file unchanged, LED holds
    issue(ADD_, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd11);
    idle();
    issue(ADD_, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 32'd22);
    chk("nowrite_led", led1, 32'd22);
    idle();
    chk("gap_ov", 32'(ov1), 32'd0);
    chk("gap_led_hold", led1, 32'd22);
    idle();
    dbg_chk("nowrite_r1", 1'b1, 5'd1, 32'd11);

    // randomized traffic with heavy register reuse
    for (int n = 0; n < 3000; n++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      ALU_OP    = 3'($urandom_range(0, 7));
      R_Addr_A  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      R_Addr_B  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      W_Addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      Write_Reg = ($urandom_range(0, 4) != 0);
      Use_Imm   = $urandom_range(0, 1) == 1;
      Imm       = pick_imm();
      Dbg_Addr  = 5'($urandom_range(0, 7));
      @(negedge clk);
    end

    // drain and sweep the whole file through the debug port
    Reset = 1'b0; in_valid = 1'b0; Write_Reg = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Dbg_Addr = 5'(i);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
